// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter
// Purpose  : Round-robin arbiter that serializes per-core byte read/write
//            requests onto the single RAM controller port, with a per-access
//            ack timeout and a one-cycle completion pulse to the winner.
// Revision : 1.0 - initial release
// ============================================================================
module ram_arbiter #(
  parameter int CORES   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [CORES-1:0]      ARB_Req,
  input  logic [CORES-1:0]      ARB_We,
  input  logic [16*CORES-1:0]   ARB_Addr,
  input  logic [8*CORES-1:0]    ARB_WData,
  output logic [CORES-1:0]      ARB_Done,
  output logic                  ARB_Err,
  output logic [7:0]            ARB_RData,
  output logic [CORES-1:0]      ARB_Owner,
  output logic [15:0]           RAM_RdAddr,
  output logic                  RAM_RdReq,
  input  logic                  RAM_RdAck,
  input  logic [7:0]            RAM_RdData,
  output logic [15:0]           RAM_WrAddr,
  output logic [7:0]            RAM_WrData,
  output logic                  RAM_WrReq,
  input  logic                  RAM_WrAccess
);

  localparam int IW    = (CORES > 1) ? $clog2(CORES) : 1;
  localparam int SUM_W = IW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nx;

  logic [IW-1:0]     rr_ptr;
  logic [IW-1:0]     owner;
  logic              we_l;
  logic [15:0]       addr_l;
  logic [7:0]        wdata_l;
  logic [7:0]        rdata_l;
  logic [7:0]        tmo_cnt;
  logic              err_l;

  logic [2*CORES-1:0] req_dbl;
  logic [CORES-1:0]   req_rot;
  logic [IW-1:0]      grant_off;
  logic [SUM_W-1:0]   grant_sum;
  logic [IW-1:0]      grant_idx;
  logic               grant_vld;
  logic               grant_we;
  logic [15:0]        grant_addr;
  logic [7:0]         grant_wdata;
  logic               tmo_hit;
  logic [IW-1:0]      rr_next;
  logic [CORES-1:0]   owner_oh;

  // Last cycle of the wait window: the access is aborted if no ack arrives now.
  assign tmo_hit  = (tmo_cnt == 8'(TIMEOUT - 1));
  assign rr_next  = (owner == IW'(CORES - 1)) ? '0 : owner + IW'(1);
  assign owner_oh = CORES'(1) << owner;

  // Rotate requests so rr_ptr sits at bit 0, pick the lowest set bit, then
  // map the offset back to a core index and select that core's operands.
  always_comb begin
    req_dbl     = {ARB_Req, ARB_Req} >> rr_ptr;
    req_rot     = req_dbl[CORES-1:0];
    grant_vld   = |req_rot;
    grant_off   = '0;
    for (int k = CORES - 1; k >= 0; k--) begin
      if (req_rot[k]) grant_off = IW'(k);
    end
    grant_sum = {1'b0, rr_ptr} + {1'b0, grant_off};
    if (grant_sum >= SUM_W'(CORES)) grant_sum = grant_sum - SUM_W'(CORES);
    grant_idx   = grant_sum[IW-1:0];
    grant_we    = 1'b0;
    grant_addr  = 16'h0000;
    grant_wdata = 8'h00;
    for (int i = 0; i < CORES; i++) begin
      if (grant_idx == IW'(i)) begin
        grant_we    = ARB_We[i];
        grant_addr  = ARB_Addr[16*i +: 16];
        grant_wdata = ARB_WData[8*i +: 8];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; acks only count in their matching state.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant_vld) state_nx = grant_we ? WRITE : READ;
      READ:    if (RAM_RdAck || tmo_hit) state_nx = DONE;
      WRITE:   if (RAM_WrAccess || tmo_hit) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Transaction registers: latched at grant, updated while waiting for the RAM.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_ptr  <= '0;
      owner   <= '0;
      we_l    <= 1'b0;
      addr_l  <= 16'h0000;
      wdata_l <= 8'h00;
      rdata_l <= 8'h00;
      tmo_cnt <= 8'h00;
      err_l   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            owner   <= grant_idx;
            we_l    <= grant_we;
            addr_l  <= grant_addr;
            wdata_l <= grant_wdata;
            rdata_l <= 8'h00;
            tmo_cnt <= 8'h00;
            err_l   <= 1'b0;
          end
        end
        READ: begin
          if (RAM_RdAck) begin
            rdata_l <= RAM_RdData;
            err_l   <= 1'b0;
          end else if (tmo_hit) begin
            rdata_l <= 8'h00;
            err_l   <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 8'h01;
          end
        end
        WRITE: begin
          if (RAM_WrAccess) begin
            err_l <= 1'b0;
          end else if (tmo_hit) begin
            err_l <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 8'h01;
          end
        end
        DONE: begin
          rr_ptr <= rr_next;
        end
        default: ;
      endcase
    end
  end

  // Outputs are decoded purely from registered state.
  assign ARB_Owner  = (state == IDLE) ? '0 : owner_oh;
  assign ARB_Done   = (state == DONE) ? owner_oh : '0;
  assign ARB_Err    = (state == DONE) && err_l;
  assign ARB_RData  = ((state == DONE) && !we_l) ? rdata_l : 8'h00;
  assign RAM_RdReq  = (state == READ);
  assign RAM_RdAddr = (state == READ) ? addr_l : 16'h0000;
  assign RAM_WrReq  = (state == WRITE);
  assign RAM_WrAddr = (state == WRITE) ? addr_l : 16'h0000;
  assign RAM_WrData = (state == WRITE) ? wdata_l : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_arbiter
// Purpose  : Directed self-checking bench for ram_arbiter (4 cores, TIMEOUT=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [3:0]  we = '0;
  logic [63:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  done;
  logic        err;
  logic [7:0]  rdata;
  logic [3:0]  owner;
  logic [15:0] rd_addr;
  logic        rd_req;
  logic        rd_ack = 1'b0;
  logic [7:0]  rd_data = '0;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_req;
  logic        wr_access = 1'b0;

  int checks = 0;
  int errors = 0;

  ram_arbiter #(.CORES(4), .TIMEOUT(8)) dut (
    .CLK(clk), .RST(rst),
    .ARB_Req(req), .ARB_We(we), .ARB_Addr(addr), .ARB_WData(wdata),
    .ARB_Done(done), .ARB_Err(err), .ARB_RData(rdata), .ARB_Owner(owner),
    .RAM_RdAddr(rd_addr), .RAM_RdReq(rd_req), .RAM_RdAck(rd_ack),
    .RAM_RdData(rd_data), .RAM_WrAddr(wr_addr), .RAM_WrData(wr_data),
    .RAM_WrReq(wr_req), .RAM_WrAccess(wr_access)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; outputs are sampled and inputs driven here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Step until a completion pulse appears, bounded by max_cyc cycles.
  task automatic wait_done(input string tag, input int max_cyc);
    int n;
    n = 0;
    step();
    while (done == 4'b0000 && n < max_cyc) begin
      step();
      n++;
    end
    chk({tag, "_seen"}, {31'd0, done != 4'b0000}, 32'd1);
  endtask

  initial begin
    int n;
    logic [3:0] exp_oh;
    int order [5];
    order = '{0, 1, 2, 3, 0};

    // Reset state
    step(); step();
    chk("rst_done", done, 0);
    chk("rst_owner", owner, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rr_wr", {rd_req, wr_req}, 0);
    chk("rst_addrs", {rd_addr, wr_addr}, 0);
    chk("rst_wdata", wr_data, 0);
    rst = 1'b0;
    step();

    // Single read: core 2 @0x1234, ack 3 cycles after RR rises
    req[2] = 1'b1; addr[32 +: 16] = 16'h1234;
    step();
    chk("rd_rr_rise", rd_req, 1);
    chk("rd_addr", rd_addr, 16'h1234);
    chk("rd_owner", owner, 4'b0100);
    step(); step();
    chk("rd_wait_nodone", done, 0);
    step();
    rd_ack = 1'b1; rd_data = 8'hA5; req[2] = 1'b0;
    step();
    rd_ack = 1'b0;
    chk("rd_done", done, 4'b0100);
    chk("rd_rdata", rdata, 8'hA5);
    chk("rd_err", err, 0);
    chk("rd_rr_fall", rd_req, 0);
    step();
    chk("rd_idle_done", done, 0);
    chk("rd_idle_owner", owner, 0);

    // Write with immediate access: core 0 writes 0x5A to 0x00FF
    req[0] = 1'b1; we[0] = 1'b1; addr[0 +: 16] = 16'h00FF; wdata[0 +: 8] = 8'h5A;
    step();
    chk("wr_req", wr_req, 1);
    chk("wr_addr", wr_addr, 16'h00FF);
    chk("wr_data", wr_data, 8'h5A);
    chk("wr_no_rr", rd_req, 0);
    wr_access = 1'b1; req[0] = 1'b0;
    step();
    wr_access = 1'b0;
    chk("wr_done", done, 4'b0001);
    chk("wr_req_one_cycle", wr_req, 0);
    chk("wr_err", err, 0);
    chk("wr_rdata", rdata, 0);
    we = '0;
    step();

    // Round-robin from a fresh reset: all cores request, immediate acks
    rst = 1'b1; step(); rst = 1'b0;
    req = 4'b1111; rd_ack = 1'b1; rd_data = 8'h3C;
    for (int k = 0; k < 5; k++) begin
      wait_done($sformatf("rr%0d", k), 6);
      exp_oh = 4'b0001 << order[k];
      chk($sformatf("rr%0d_done", k), done, exp_oh);
      chk($sformatf("rr%0d_rdata", k), rdata, 8'h3C);
    end
    req = '0; rd_ack = 1'b0;
    step();
    chk("rr_idle_owner", owner, 0);

    // Timeout: core 1 read never acked (rr_ptr is 1)
    req[1] = 1'b1;
    step();
    chk("to_rr_rise", rd_req, 1);
    req[1] = 1'b0;
    n = 0;
    while (rd_req && n < 20) begin
      n++;
      step();
    end
    chk("to_rr_cycles", n, 8);
    chk("to_done", done, 4'b0010);
    chk("to_err", err, 1);
    chk("to_rdata", rdata, 0);
    step();
    chk("to_idle_owner", owner, 0);

    // Reset in the middle of a read (rr_ptr is 2 before the reset)
    req[1] = 1'b1;
    step(); step();
    chk("mr_rr_high", rd_req, 1);
    rst = 1'b1; req = '0;
    step();
    chk("mr_rr_drop", rd_req, 0);
    chk("mr_no_done", done, 0);
    chk("mr_owner", owner, 0);
    rst = 1'b0;
    step();
    req = 4'b1010;
    step();
    chk("mr_scan_from0", owner, 4'b0010);
    req = 4'b1000; rd_ack = 1'b1; rd_data = 8'h11;
    step();
    chk("mr_done1", done, 4'b0010);
    chk("mr_rdata1", rdata, 8'h11);
    wait_done("mr_core3", 6);
    chk("mr_done3", done, 4'b1000);
    req = '0; rd_ack = 1'b0;
    step();

    // Spurious acks while idle and during a write
    rd_ack = 1'b1; wr_access = 1'b1;
    step(); step();
    chk("sp_idle_owner", owner, 0);
    chk("sp_idle_done", done, 0);
    chk("sp_idle_strobes", {rd_req, wr_req}, 0);
    rd_ack = 1'b0; wr_access = 1'b0;
    req[2] = 1'b1; we[2] = 1'b1; addr[32 +: 16] = 16'hBEEF; wdata[16 +: 8] = 8'h77;
    step();
    chk("sp_wr_req", wr_req, 1);
    req = '0; we = '0; rd_ack = 1'b1; addr[32 +: 16] = 16'h0000; wdata[16 +: 8] = 8'h00;
    step();
    chk("sp_wr_still", wr_req, 1);
    chk("sp_wr_nodone", done, 0);
    chk("sp_wr_addr_held", wr_addr, 16'hBEEF);
    chk("sp_wr_data_held", wr_data, 8'h77);
    chk("sp_wr_no_rr", rd_req, 0);
    step();
    chk("sp_wr_still2", wr_req, 1);
    rd_ack = 1'b0; wr_access = 1'b1;
    step();
    wr_access = 1'b0;
    chk("sp_wr_done", done, 4'b0100);
    chk("sp_wr_err", err, 0);
    chk("sp_wr_rdata", rdata, 0);
    step();
    chk("sp_end_owner", owner, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ram_arbiter.md
# ram_arbiter

Round-robin arbiter that shares the single RAM controller port among the execution units of all PLC cores. Each core issues one byte read or write request. The arbiter picks one requester, drives the RAM controller's read (ADDR/RR, wait ACK) or write (ADDR/DATA/WR, wait ACCESS) interface, and returns completion to that core. It sits between the per-core EXE stages and the RAM controller, and it serializes every RAM access in the unit.

## Interface
- CORES, default 4: number of requesting cores (2..8).
- TIMEOUT, default 255: maximum number of cycles to wait for RAM ACK/ACCESS before aborting (1..255).

- CLK  in  1  single clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- ARB_Req  in  CORES  per-core request level; held until that core's ARB_Done.
- ARB_We  in  CORES  per-core direction: 1 = write, 0 = read; sampled at grant.
- ARB_Addr  in  16*CORES  per-core address; core i is bits [16i+15:16i].
- ARB_WData  in  8*CORES  per-core write byte; core i is bits [8i+7:8i].
- ARB_Done  out  CORES  one-cycle completion pulse to the granted core.
- ARB_Err  out  1  high together with ARB_Done when the access timed out.
- ARB_RData  out  8  read byte; valid while ARB_Done is high for a read.
- ARB_Owner  out  CORES  one-hot current grant; 0 when idle.
- RAM_RdAddr  out  16  read address to the RAM controller.
- RAM_RdReq  out  1  read request (RR), level.
- RAM_RdAck  in  1  read acknowledge; RAM_RdData is valid in the same cycle.
- RAM_RdData  in  8  read byte.
- RAM_WrAddr  out  16  write address.
- RAM_WrData  out  8  write byte.
- RAM_WrReq  out  1  write strobe (WR), level.
- RAM_WrAccess  in  1  write accepted.

## Operation
- FSM states: IDLE, READ, WRITE, DONE. Reset puts the FSM in IDLE.
- Internal registers: rr_ptr (index of the highest-priority core), owner, we_l, addr_l, wdata_l, rdata_l, tmo_cnt (8 bits).
- **IDLE**
  - If no ARB_Req bit is set, stay in IDLE.
  - Otherwise, scan from rr_ptr upward modulo CORES and grant the first set bit.
  - On grant, latch owner, ARB_We, ARB_Addr and ARB_WData for that core, clear tmo_cnt, and go to READ (We=0) or WRITE (We=1).
- **READ**
  - RAM_RdReq=1. RAM_RdAddr=addr_l.
  - When RAM_RdAck=1: capture RAM_RdData into rdata_l and go to DONE with err=0.
  - Otherwise increment tmo_cnt. When tmo_cnt reaches TIMEOUT-1 without an ack, go to DONE with err=1 and rdata_l=0.
- **WRITE**
  - RAM_WrReq=1. RAM_WrAddr=addr_l. RAM_WrData=wdata_l.
  - When RAM_WrAccess=1, go to DONE with err=0. The same timeout rule as READ applies.
- **DONE**
  - ARB_Done[owner]=1 and ARB_Err=err.
  - ARB_RData=rdata_l (0 for writes).
  - rr_ptr is set to (owner+1) mod CORES. The FSM returns to IDLE.
- ARB_Owner is one-hot of owner in READ, WRITE and DONE; it is 0 in IDLE.
- Request changes after grant:
  - If the granted core drops ARB_Req mid-transaction, the transaction still completes and ARB_Done still pulses.
  - Changes to ARB_Addr, ARB_WData or ARB_We after grant are ignored.
- Acks outside the matching state are ignored: RAM_RdAck outside READ, and RAM_WrAccess outside WRITE.
- Exactly one RAM request is outstanding at any time. RAM_RdReq and RAM_WrReq are never high in the same cycle.

## Timing
- Reset values:
  - FSM in IDLE, rr_ptr=0.
  - All outputs 0: ARB_Done, ARB_Err, ARB_RData, ARB_Owner, RAM_RdReq, RAM_WrReq, RAM_RdAddr, RAM_WrAddr, RAM_WrData.
- All outputs are registered or decoded from registered state; there is no combinational path from any input to any output.
- Cycle sequence, with the request sampled high in IDLE at edge t:
  - The request strobe is high from cycle t+1.
  - An ack in cycle t+k (k≥1) gives ARB_Done in cycle t+k+1.
  - The FSM is back in IDLE at cycle t+k+2.
  - Minimum grant-to-done latency is therefore 2 cycles, and each access occupies the RAM for at least 3 cycles.
- A requester must have ARB_Req low in the cycle after its ARB_Done unless it intends a new transaction. If ARB_Req is still high there, it is treated as a new request, subject to round-robin.
- A timeout fires with ARB_Done+ARB_Err exactly TIMEOUT cycles after the strobe first rises.
- Reset asserted mid-transaction:
  - The next edge returns the FSM to IDLE and drops the strobe.
  - No ARB_Done is issued and rr_ptr resets to 0.
- Fairness: a continuously requesting core waits at most CORES-1 transactions before it is granted.

## Test plan
- Reset then a single read: core 2 reads 0x1234, and the RAM acks 3 cycles after RR rises with data 0xA5 -> RAM_RdAddr=0x1234, ARB_Done=4'b0100 for one cycle with ARB_RData=0xA5, ARB_Err=0.
- Write with immediate access: core 0 writes 0x5A to 0x00FF, and WrAccess is high in the first WR cycle -> WR high for exactly 1 cycle, ARB_Done=4'b0001 two cycles after the request is sampled.
- Round-robin: all 4 cores request continuously with immediate acks -> grant order 0,1,2,3,0. No core is granted twice before all other requesters are served.
- Timeout: TIMEOUT=8 and a read that is never acked -> after 8 cycles of RR, ARB_Done and ARB_Err pulse together, ARB_RData=0, and the FSM returns to IDLE.
- Reset mid-read: RST is asserted while RR is high -> RR=0 next cycle, no ARB_Done, and a subsequent request from core 3 is granted after core-0-first scan order.
- Spurious acks: RAM_RdAck and RAM_WrAccess pulse while IDLE, and RdAck pulses during a WRITE -> no state change, no ARB_Done, and the write still waits for WrAccess.
